// File: rtl/tagram_pkg.sv
// Shared types and helpers for the tagged RAM slave and its storage array.
// Parity support is compiled in only when TAGRAM_PARITY_EN is defined.
package tagram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int CNT_W     = 4;
  localparam int PAR_MAX_W = 512;

  // Callers zero-extend their word to PAR_MAX_W, which leaves the XOR unchanged.
  function automatic logic calcParity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/tagram_array.sv
// Word storage for the tagged RAM slave: synchronous write, registered read.
// The read register is cleared by reset; the memory contents are not.
module tagram_array #(
  parameter int WORD_W = 72,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn_i,
  input  logic [IDX_W-1:0]  wrAddr_i,
  input  logic [WORD_W-1:0] wrWord_i,
  input  logic              rdEn_i,
  input  logic [IDX_W-1:0]  rdAddr_i,
  output logic [WORD_W-1:0] rdWord_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdWord_q;

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrWord_i;
    end
  end

  // The read register only moves on a response, so the word holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdWord_q <= '0;
    end else if (rdEn_i) begin
      rdWord_q <= mem_q[rdAddr_i];
    end
  end

  assign rdWord_o = rdWord_q;

endmodule

// File: rtl/tagged_ram_slave.sv
// Tagged-memory bus slave: address latch, read FSM with wait states, burst auto-increment.
// Define TAGRAM_PARITY_EN to store and check one parity bit per word.
module tagged_ram_slave
  import tagram_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 8,
  parameter int ADDR_W  = 20,
  parameter int DEPTH   = 1 << 20,
  parameter int RD_WAIT = 0,
  parameter int AUTOINC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_ad,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_astb,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_err
);

`ifdef TAGRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + TAG_W + PAR_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              err_q, err_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] rspAddr;
  logic              busy, acceptWr, acceptRd, waddrOor, rspOor, latchResp, parErr;
  logic [WORD_W-1:0] wrWord, rdWord;

  assign busy      = (state_q == WAIT);
  assign acceptWr  = i_wr && !i_astb && !busy;
  assign acceptRd  = i_rd && !i_astb && !i_wr && !busy;
  assign waddrOor  = ({1'b0, waddr_q} >= DEPTH_L);
  assign rspAddr   = (RD_WAIT == 0) ? waddr_q : raddr_q;
  assign rspOor    = ({1'b0, rspAddr} >= DEPTH_L);
  // The edge that enters RESP is the one that samples the array.
  assign latchResp = (RD_WAIT == 0) ? acceptRd : (busy && (cnt_q == WAIT_LAST));

`ifdef TAGRAM_PARITY_EN
  assign wrWord = {calcParity(PAR_MAX_W'({i_ad, i_tag})), i_ad, i_tag};
  assign parErr = calcParity(PAR_MAX_W'(rdWord[DATA_W+TAG_W-1:0])) != rdWord[WORD_W-1];
`else
  assign wrWord = {i_ad, i_tag};
  assign parErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    oor_d   = oor_q;
    err_d   = (acceptWr && waddrOor) || (latchResp && rspOor);

    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (acceptRd) begin
      raddr_d = waddr_q;
      cnt_d   = '0;
      state_d = (RD_WAIT == 0) ? RESP : WAIT;
    end

    if (latchResp) begin
      oor_d = rspOor;
    end

    // An out-of-range address is left where it is rather than wrapped.
    if (i_astb) begin
      waddr_d = i_ad[ADDR_W-1:0];
    end else if ((acceptWr || acceptRd) && (AUTOINC != 0) && !waddrOor) begin
      waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      err_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
      oor_q   <= oor_d;
    end
  end

  tagram_array #(
    .WORD_W(WORD_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wrEn_i  (acceptWr && !waddrOor),
    .wrAddr_i(waddr_q[IDX_W-1:0]),
    .wrWord_i(wrWord),
    .rdEn_i  (latchResp && !rspOor),
    .rdAddr_i(rspAddr[IDX_W-1:0]),
    .rdWord_o(rdWord)
  );

  assign o_data  = oor_q ? '0 : rdWord[TAG_W +: DATA_W];
  assign o_tag   = oor_q ? '0 : rdWord[TAG_W-1:0];
  assign o_valid = (state_q == RESP);
  assign o_busy  = busy;
  assign o_err   = err_q || (o_valid && !oor_q && parErr);

endmodule

// File: tb/tb_tagged_ram_slave.sv
// Bench for tagged_ram_slave: two instances (RD_WAIT=0 and RD_WAIT=3) share one stimulus
// stream and are compared against a cycle-indexed transaction model of the bus rules.
module tb_tagged_ram_slave;

  localparam int DEP = 1024;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [63:0] ad;
  logic [7:0]  tag;
  logic        astb, rd, wr;
  logic [63:0] data0, data3;
  logic [7:0]  tag0, tag3;
  logic        valid0, valid3, busy0, busy3, err0, err3;

  always #5 clk = ~clk;

  tagged_ram_slave #(
    .DATA_W(64), .TAG_W(8), .ADDR_W(20), .DEPTH(DEP), .RD_WAIT(0), .AUTOINC(1)
  ) dut0 (
    .clk(clk), .reset(rstN), .i_ad(ad), .i_tag(tag), .i_astb(astb), .i_rd(rd), .i_wr(wr),
    .o_data(data0), .o_tag(tag0), .o_valid(valid0), .o_busy(busy0), .o_err(err0)
  );

  tagged_ram_slave #(
    .DATA_W(64), .TAG_W(8), .ADDR_W(20), .DEPTH(DEP), .RD_WAIT(3), .AUTOINC(1)
  ) dut3 (
    .clk(clk), .reset(rstN), .i_ad(ad), .i_tag(tag), .i_astb(astb), .i_rd(rd), .i_wr(wr),
    .o_data(data3), .o_tag(tag3), .o_valid(valid3), .o_busy(busy3), .o_err(err3)
  );

  int passCount  = 0;
  int checkCount = 0;
  int edgeNum    = 0;
  bit modelOn    = 1'b1;

  // Reference model: a read accepted at edge k responds in the cycle after edge k+RD_WAIT.
  int          rdWaitOf [2] = '{0, 3};
  int          mAddr [2];
  bit          mPend [2];
  int          mRespEdge [2];
  logic [63:0] mRespData [2];
  logic [7:0]  mRespTag [2];
  bit          mRespErr [2];
  bit          mRespKnown [2];
  logic [63:0] eData [2];
  logic [7:0]  eTag [2];
  bit          eKnown [2], eValid [2], eBusy [2], eErr [2];
  logic [71:0] mMem [int];

  typedef struct {
    string       name;
    logic        a, w, r;
    logic [63:0] d;
    logic [7:0]  t;
    logic        expValid, expErr, chkData;
    logic [63:0] expData;
    logic [7:0]  expTag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input string n, input logic a, input logic w, input logic r,
                                 input logic [63:0] d, input logic [7:0] t, input logic v,
                                 input logic e, input logic c, input logic [63:0] ed,
                                 input logic [7:0] et);
    vec_t x;
    x.name = n; x.a = a; x.w = w; x.r = r; x.d = d; x.t = t;
    x.expValid = v; x.expErr = e; x.chkData = c; x.expData = ed; x.expTag = et;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mAddr[i] = 0; mPend[i] = 1'b0; mRespEdge[i] = 0;
      eData[i] = '0; eTag[i] = '0; eKnown[i] = 1'b1;
      eValid[i] = 1'b0; eBusy[i] = 1'b0; eErr[i] = 1'b0;
    end
  endtask

  task automatic modelStep(input int i);
    bit busyBefore;
    int key;
    busyBefore = mPend[i] && (edgeNum <= mRespEdge[i]);
    eErr[i] = 1'b0;
    if (astb) begin
      mAddr[i] = int'(ad[19:0]);
    end else if (wr && !busyBefore) begin
      if (mAddr[i] >= DEP) begin
        eErr[i] = 1'b1;
      end else begin
        mMem[i * 4096 + mAddr[i]] = {ad, tag};
        mAddr[i] = (mAddr[i] + 1) % DEP;
      end
    end else if (rd && !busyBefore) begin
      mPend[i] = 1'b1;
      mRespEdge[i] = edgeNum + rdWaitOf[i];
      if (mAddr[i] >= DEP) begin
        mRespData[i] = '0; mRespTag[i] = '0; mRespKnown[i] = 1'b1; mRespErr[i] = 1'b1;
      end else begin
        key = i * 4096 + mAddr[i];
        mRespErr[i] = 1'b0;
        mRespKnown[i] = mMem.exists(key);
        if (mRespKnown[i]) {mRespData[i], mRespTag[i]} = mMem[key];
        mAddr[i] = (mAddr[i] + 1) % DEP;
      end
    end
    eValid[i] = mPend[i] && (mRespEdge[i] == edgeNum);
    if (eValid[i]) begin
      eData[i] = mRespData[i]; eTag[i] = mRespTag[i]; eKnown[i] = mRespKnown[i];
      if (mRespErr[i]) eErr[i] = 1'b1;
    end
    eBusy[i] = mPend[i] && (edgeNum < mRespEdge[i]);
  endtask

  task automatic compareModel();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "dut0" : "dut3";
      checkOutput({p, " valid"}, 64'((i == 0) ? valid0 : valid3), 64'(eValid[i]));
      checkOutput({p, " busy"},  64'((i == 0) ? busy0 : busy3),   64'(eBusy[i]));
      checkOutput({p, " err"},   64'((i == 0) ? err0 : err3),     64'(eErr[i]));
      if (eKnown[i]) begin
        checkOutput({p, " data"}, (i == 0) ? data0 : data3, eData[i]);
        checkOutput({p, " tag"},  64'((i == 0) ? tag0 : tag3), 64'(eTag[i]));
      end
    end
  endtask

  // One bus cycle: drive inputs, let the edge happen, check on the falling edge.
  task automatic applyStimulus(input logic a, input logic w, input logic r,
                               input logic [63:0] d, input logic [7:0] t);
    astb = a; wr = w; rd = r; ad = d; tag = t;
    @(posedge clk);
    edgeNum++;
    if (rstN) begin
      modelStep(0);
      modelStep(1);
    end
    @(negedge clk);
    if (modelOn) compareModel();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
  endtask

  task automatic checkAllZero(input string n);
    checkOutput({n, " data0"}, data0, 64'h0);
    checkOutput({n, " tag0"}, 64'(tag0), 64'h0);
    checkOutput({n, " valid0"}, 64'(valid0), 64'h0);
    checkOutput({n, " busy0"}, 64'(busy0), 64'h0);
    checkOutput({n, " err0"}, 64'(err0), 64'h0);
    checkOutput({n, " data3"}, data3, 64'h0);
    checkOutput({n, " tag3"}, 64'(tag3), 64'h0);
    checkOutput({n, " valid3"}, 64'(valid3), 64'h0);
    checkOutput({n, " busy3"}, 64'(busy3), 64'h0);
    checkOutput({n, " err3"}, 64'(err3), 64'h0);
  endtask

  task automatic doReset();
    astb = 1'b0; wr = 1'b0; rd = 1'b0; ad = '0; tag = '0;
    rstN = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  function automatic logic [19:0] pickAddr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 20'($urandom_range(0, 15));
      3, 4:    return 20'($urandom_range(DEP - 6, DEP - 1));
      default: return 20'($urandom_range(DEP, DEP + 3));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    astb = 1'b0; wr = 1'b0; rd = 1'b0; ad = '0; tag = '0;
    #1;
    doReset();
    checkAllZero("reset");

    vecs.push_back(mkVec("astb10",    1,0,0, 64'h10, 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("wr10",      0,1,0, 64'h0123456789ABCDEF, 8'h5A, 0,0,1, 64'h0, 8'h00));
    vecs.push_back(mkVec("astb10b",   1,0,0, 64'h10, 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("rd10",      0,0,1, 64'h0, 8'h00, 1,0,1, 64'h0123456789ABCDEF, 8'h5A));
    vecs.push_back(mkVec("hold",      0,0,0, 64'h0, 8'h00, 0,0,1, 64'h0123456789ABCDEF, 8'h5A));
    vecs.push_back(mkVec("astbWr",    1,1,0, 64'h10, 8'h11, 0,0,1, 64'h0123456789ABCDEF, 8'h5A));
    vecs.push_back(mkVec("rdUnchg",   0,0,1, 64'h0, 8'h00, 1,0,1, 64'h0123456789ABCDEF, 8'h5A));
    vecs.push_back(mkVec("astbOor",   1,0,0, 64'h400, 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("wrOor",     0,1,0, 64'hDEAD, 8'h33, 0,1,1, 64'h0123456789ABCDEF, 8'h5A));
    vecs.push_back(mkVec("rdOor",     0,0,1, 64'h0, 8'h00, 1,1,1, 64'h0, 8'h00));
    vecs.push_back(mkVec("holdOor",   0,0,0, 64'h0, 8'h00, 0,0,1, 64'h0, 8'h00));
    vecs.push_back(mkVec("astbEnd",   1,0,0, 64'(DEP - 2), 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("wrB1",      0,1,0, 64'hA1A1A1A1, 8'h01, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("wrB2",      0,1,0, 64'hA2A2A2A2, 8'h02, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("wrB3",      0,1,0, 64'hA3A3A3A3, 8'h03, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("astbEnd2",  1,0,0, 64'(DEP - 2), 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("rdB1",      0,0,1, 64'h0, 8'h00, 1,0,1, 64'hA1A1A1A1, 8'h01));
    vecs.push_back(mkVec("rdB2",      0,0,1, 64'h0, 8'h00, 1,0,1, 64'hA2A2A2A2, 8'h02));
    vecs.push_back(mkVec("rdB3wrap",  0,0,1, 64'h0, 8'h00, 1,0,1, 64'hA3A3A3A3, 8'h03));
    vecs.push_back(mkVec("astb0",     1,0,0, 64'h0, 8'h00, 0,0,0, 64'h0, 8'h00));
    vecs.push_back(mkVec("rdAddr0",   0,0,1, 64'h0, 8'h00, 1,0,1, 64'hA3A3A3A3, 8'h03));

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].a, vecs[n].w, vecs[n].r, vecs[n].d, vecs[n].t);
      checkOutput({vecs[n].name, " valid"}, 64'(valid0), 64'(vecs[n].expValid));
      checkOutput({vecs[n].name, " err"}, 64'(err0), 64'(vecs[n].expErr));
      if (vecs[n].chkData) begin
        checkOutput({vecs[n].name, " data"}, data0, vecs[n].expData);
        checkOutput({vecs[n].name, " tag"}, 64'(tag0), 64'(vecs[n].expTag));
      end
    end

    // Wait states on dut3, with a write during busy that must be ignored.
    idle(4);
    applyStimulus(1, 0, 0, 64'h100, 8'h00);
    applyStimulus(0, 1, 0, 64'h1111_0000_0000_0001, 8'h71);
    applyStimulus(0, 1, 0, 64'h2222_0000_0000_0002, 8'h72);
    applyStimulus(1, 0, 0, 64'h100, 8'h00);
    applyStimulus(0, 0, 1, 64'h0, 8'h00);
    checkOutput("wait busy k", 64'(busy3), 64'h1);
    checkOutput("wait novalid k", 64'(valid3), 64'h0);
    applyStimulus(0, 1, 0, 64'h3333_0000_0000_0003, 8'h73);
    checkOutput("wait busy k+1", 64'(busy3), 64'h1);
    idle(1);
    checkOutput("wait busy k+2", 64'(busy3), 64'h1);
    idle(1);
    checkOutput("wait valid k+3", 64'(valid3), 64'h1);
    checkOutput("wait unbusy k+3", 64'(busy3), 64'h0);
    checkOutput("wait data k+3", data3, 64'h1111_0000_0000_0001);
    checkOutput("wait tag k+3", 64'(tag3), 64'h71);
    applyStimulus(0, 0, 1, 64'h0, 8'h00);
    checkOutput("b2b busy", 64'(busy3), 64'h1);
    idle(2);
    checkOutput("b2b novalid", 64'(valid3), 64'h0);
    idle(1);
    checkOutput("b2b valid", 64'(valid3), 64'h1);
    checkOutput("ignored wr data", data3, 64'h2222_0000_0000_0002);
    checkOutput("ignored wr tag", 64'(tag3), 64'h72);

    // Reset asserted during WAIT aborts the read immediately.
    applyStimulus(1, 0, 0, 64'h100, 8'h00);
    applyStimulus(0, 0, 1, 64'h0, 8'h00);
    checkOutput("pre-reset busy", 64'(busy3), 64'h1);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    checkAllZero("async reset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, 64'h0, 8'h00);
      checkOutput("no valid after reset", 64'(valid3), 64'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic a, w, r;
      logic [63:0] d;
      a = ($urandom_range(0, 4) == 0);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      d = {$urandom, $urandom};
      if (a) d[19:0] = pickAddr();
      applyStimulus(a, w, r, d, 8'($urandom));
    end

`ifdef TAGRAM_PARITY_EN
    modelOn = 1'b0;
    idle(4);
    applyStimulus(1, 0, 0, 64'h200, 8'h00);
    applyStimulus(0, 1, 0, 64'h0F0F_1234_5678_9ABC, 8'hC3);
    applyStimulus(1, 0, 0, 64'h200, 8'h00);
    dut0.u_array.mem_q[512][20] = ~dut0.u_array.mem_q[512][20];
    applyStimulus(0, 0, 1, 64'h0, 8'h00);
    checkOutput("parity valid", 64'(valid0), 64'h1);
    checkOutput("parity err", 64'(err0), 64'h1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tagged_ram_slave.md
# tagged_ram_slave

Synthesizable, parametrised tagged-memory bus slave for the CPU's multiplexed address/data bus. Latches the word address on an address strobe, then serves word-wide data plus tag reads and writes. Adds configurable read wait states, burst auto-increment with wrap, and out-of-range detection. Replaces the behavioural memory model in the CPU bench and is the memory block for FPGA builds.

## Interface
Parameters:
- DATA_W, 64, data word width
- TAG_W, 8, tag width per word
- ADDR_W, 20, latched address width, taken from i_ad[ADDR_W-1:0]
- DEPTH, 1<<20, words implemented, DEPTH <= 2**ADDR_W
- RD_WAIT, 0, extra read wait cycles, 0..15
- AUTOINC, 1, 1 = address increments after every accepted rd/wr

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_ad  in  DATA_W  address (when i_astb) or write data
- i_tag  in  TAG_W  write tag
- i_astb  in  1  address strobe
- i_rd  in  1  read request
- i_wr  in  1  write request
- o_data  out  DATA_W  read data, valid with o_valid
- o_tag  out  TAG_W  read tag, valid with o_valid
- o_valid  out  1  read response, one-cycle pulse
- o_busy  out  1  read in progress, requests ignored
- o_err  out  1  one-cycle pulse: access beyond DEPTH (or parity error)

## Operation
- Command priority per edge: i_astb > i_wr > i_rd; lower-priority requests in the same cycle are dropped.
- i_astb: waddr <= i_ad[ADDR_W-1:0]. Accepted even while o_busy. It does not change the address of a read already in flight.
- i_wr with o_busy=0: mem[waddr] <= i_ad, tags[waddr] <= i_tag. If waddr >= DEPTH, the write is dropped and o_err pulses.
- i_rd with o_busy=0: captures waddr, then enters WAIT, or RESP if RD_WAIT=0.
- States:
  - IDLE: no read in progress.
  - WAIT: counts RD_WAIT cycles, then moves to RESP.
  - RESP: o_valid=1 for one cycle, then IDLE, or straight to WAIT/RESP if a new i_rd is accepted in the same cycle.
- An out-of-range read returns data=0, tag=0, o_valid=1 and o_err=1.
- i_rd/i_wr while o_busy=1 are ignored; no queuing.
- AUTOINC=1: after an accepted rd/wr, waddr <= (waddr==DEPTH-1) ? 0 : waddr+1. An out-of-range waddr is not incremented.
- Memory contents are not reset.

## Timing
- Reset values: o_data=0, o_tag=0, o_valid=0, o_busy=0, o_err=0, waddr=0, state IDLE.
- Read accepted at edge k:
  - o_busy=1 for the RD_WAIT cycles after edge k.
  - o_valid=1 in the cycle after edge k+RD_WAIT.
  - RD_WAIT=0 gives 1-cycle latency and one read per cycle.
- o_busy is 0 during the RESP cycle, so an i_rd in the RESP cycle is accepted (back-to-back burst).
- o_data/o_tag hold their last value outside o_valid.
- Write completes at its edge. A read of the same address at the next edge returns the new data.
- Reset asserted mid-read: immediate abort, outputs reach their reset values asynchronously, and no o_valid follows.

## Configuration
- TAGRAM_PARITY_EN defined:
  - One extra parity bit per word, the XOR of data and tag, is stored on every write.
  - A read mismatch pulses o_err together with o_valid; the data is still returned.
- Not defined: no parity storage, and o_err reports range errors only.

## Structure
- Package tagram_pkg:
  - state enum (IDLE, WAIT, RESP)
  - parity function
  - wait-counter width constant of 4 bits
- Sub-module tagram_array:
  - storage for DEPTH words of DATA_W+TAG_W(+1) bits
  - synchronous write, registered read
- Top level holds the address latch, FSM, counter and range check.

## Test plan
- Reset, then astb 0x00010, wr data 0x0123456789ABCDEF tag 0x5A, astb 0x00010, rd, RD_WAIT=0 -> o_valid on the next cycle with that data and tag 0x5A, o_err=0.
- RD_WAIT=3, rd at edge k -> o_busy high for 3 cycles, o_valid in the cycle after k+3; an i_wr during busy leaves memory unchanged.
- AUTOINC burst: astb DEPTH-2, write 3 words, then read them back -> addresses DEPTH-2, DEPTH-1, 0 in that order.
- DEPTH=1024, ADDR_W=20, astb 0x00400, wr then rd -> both pulse o_err; the read returns 0/0.
- Same-cycle astb+wr -> only the address updates; memory is unchanged.
- Reset asserted during WAIT -> all outputs 0 at once, no o_valid afterwards. With TAGRAM_PARITY_EN, flip a stored bit through a hierarchical force -> read gives o_err=1 with o_valid.
